// File: rtl/e05_response_checker.sv
// e05_response_checker: on-board self-checking harness for the E05 exercise.
// Sweeps the 3-bit stimulus a,b,c through vectors 0..7, holds each vector for
// SETTLE_CYCLES cycles, samples {f,g,h,l} and compares it with nibble idx of
// EXP_TABLE. Reports pass/fail, mismatch count and the first failing vector.
// Optional feature: define E05_CHECKER_MISR_EN to build an 8-bit MISR over the
// sampled responses; otherwise signature is tied to zero.
module e05_response_checker #(
  parameter int unsigned SETTLE_CYCLES = 2,            // legal range 1..15
  parameter logic [31:0] EXP_TABLE     = 32'h7654_3210
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a,
  output logic       b,
  output logic       c,
  input  logic       f,
  input  logic       g,
  input  logic       h,
  input  logic       l,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [2:0] first_fail_idx,
  output logic       first_fail_valid,
  output logic [7:0] signature
);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  // Last value of the settle counter before moving on to SAMPLE.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] err_q, err_d;
  logic [2:0] ffi_q, ffi_d;
  logic       ffv_q, ffv_d;

  logic [3:0] resp;
  logic [3:0] exp_nib;
  logic       mismatch;

  assign resp     = {f, g, h, l};
  assign exp_nib  = EXP_TABLE[{idx_q, 2'b00} +: 4];
  assign mismatch = (resp != exp_nib);

`ifdef E05_CHECKER_MISR_EN
  logic [7:0] sig_q, sig_d;
  logic [7:0] sig_step;

  // One MISR step: shift left, fold in polynomial 0x1D on carry-out, xor response.
  assign sig_step = ({sig_q[6:0], 1'b0} ^ (sig_q[7] ? 8'h1D : 8'h00)) ^ {4'b0000, resp};
`endif

  // Next-state logic for the sweep FSM and the result registers.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ffi_d   = ffi_q;
    ffv_d   = ffv_q;
`ifdef E05_CHECKER_MISR_EN
    sig_d   = sig_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = DRIVE;
          idx_d   = 3'd0;
          cnt_d   = 4'd0;
          err_d   = 4'd0;
          ffi_d   = 3'd0;
          ffv_d   = 1'b0;
`ifdef E05_CHECKER_MISR_EN
          sig_d   = 8'h00;
`endif
        end
      end
      DRIVE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = SAMPLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      SAMPLE: begin
        if (mismatch) begin
          err_d = err_q + 4'd1;
          if (!ffv_q) begin
            ffi_d = idx_q;
            ffv_d = 1'b1;
          end
        end
`ifdef E05_CHECKER_MISR_EN
        sig_d = sig_step;
`endif
        if (idx_q == 3'd7) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = DRIVE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      cnt_q   <= 4'd0;
      err_q   <= 4'd0;
      ffi_q   <= 3'd0;
      ffv_q   <= 1'b0;
`ifdef E05_CHECKER_MISR_EN
      sig_q   <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ffi_q   <= ffi_d;
      ffv_q   <= ffv_d;
`ifdef E05_CHECKER_MISR_EN
      sig_q   <= sig_d;
`endif
    end
  end

  // Stimulus comes straight from the registered vector index, so it holds the
  // last vector (1,1,1) in DONE and returns to 0 on reset.
  assign a = idx_q[2];
  assign b = idx_q[1];
  assign c = idx_q[0];

  assign busy             = (state_q == DRIVE) || (state_q == SAMPLE);
  assign done             = (state_q == DONE);
  assign pass             = (state_q == DONE) && (err_q == 4'd0);
  assign err_count        = err_q;
  assign first_fail_idx   = ffi_q;
  assign first_fail_valid = ffv_q;

`ifdef E05_CHECKER_MISR_EN
  assign signature = sig_q;
`else
  assign signature = 8'h00;
`endif

endmodule

// File: tb/tb_e05_response_checker.sv
// Self-checking bench for e05_response_checker: timed sweep, table of fault
// models, start/reset corner sequences and randomized response tables checked
// against a vector-by-vector reference model.
module tb_e05_response_checker;

  localparam logic [31:0] EXP = 32'h7654_3210;

  logic       clk = 1'b0;
  logic       rst, start;
  logic       a, b, c, f, g, h, l;
  logic       busy, done, pass, first_fail_valid;
  logic [3:0] err_count;
  logic [2:0] first_fail_idx;
  logic [7:0] signature;
  logic [31:0] lut;   // response of the emulated exercise block, nibble per vector

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign {f, g, h, l} = lut[{a, b, c, 2'b00} +: 4];

  e05_response_checker #(.SETTLE_CYCLES(2), .EXP_TABLE(EXP)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a(a), .b(b), .c(c), .f(f), .g(g), .h(h), .l(l),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_fail_idx(first_fail_idx), .first_fail_valid(first_fail_valid),
    .signature(signature)
  );

  typedef struct {
    string       name;
    logic [31:0] lut;
    int          err;
    int          ffi;
    int          ffv;
    int          pas;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: walk the eight vectors, compare nibbles, fold the MISR.
  function automatic void model(input logic [31:0] tbl, output int e, output int fi,
                                output int fv, output int p, output int sig);
    int s;
    e = 0; fi = 0; fv = 0; s = 0;
    for (int i = 0; i < 8; i++) begin
      int got, want;
      got  = int'((tbl >> (4 * i)) & 32'hF);
      want = int'((EXP >> (4 * i)) & 32'hF);
      if (got != want) begin
        e++;
        if (fv == 0) begin fi = i; fv = 1; end
      end
      s = ((s * 2) & 255) ^ (((s & 128) != 0) ? 29 : 0) ^ got;
    end
    p = (e == 0) ? 1 : 0;
`ifdef E05_CHECKER_MISR_EN
    sig = s;
`else
    sig = 0;
`endif
  endfunction

  task automatic start_sweep();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    chk({nm, "_done_timeout"}, int'(done), 1);
  endtask

  task automatic check_result(input string nm, input int e, input int fi,
                              input int fv, input int p, input int sig);
    chk({nm, "_err"}, int'(err_count), e);
    chk({nm, "_ffv"}, int'(first_fail_valid), fv);
    if (fv != 0) chk({nm, "_ffi"}, int'(first_fail_idx), fi);
    chk({nm, "_pass"}, int'(pass), p);
    chk({nm, "_busy"}, int'(busy), 0);
    chk({nm, "_abc"}, int'({a, b, c}), 7);
    chk({nm, "_sig"}, int'(signature), sig);
    $display("sweep %s lut=%08h err=%0d ffv=%0d ffi=%0d pass=%0d sig=%02h",
             nm, lut, err_count, first_fail_valid, first_fail_idx, pass, signature);
  endtask

  initial begin
    vec_t tbl[4];
    int e, fi, fv, p, sig;

    tbl[0] = '{"echo",        32'h7654_3210, 0, 0, 0, 1};
    tbl[1] = '{"l_stuck0",    32'h6644_2200, 4, 1, 1, 0};
    tbl[2] = '{"h_inv_idx6",  32'h7454_3210, 1, 6, 1, 0};
    tbl[3] = '{"all_wrong",   32'h89AB_CDEF, 8, 0, 1, 0};

    rst = 1'b1; start = 1'b0; lut = EXP;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pass", int'(pass), 0);
    chk("rst_abc", int'({a, b, c}), 0);
    chk("rst_err", int'(err_count), 0);
    chk("rst_ffv", int'(first_fail_valid), 0);
    chk("rst_ffi", int'(first_fail_idx), 0);
    chk("rst_sig", int'(signature), 0);

    // Timed echo sweep: vector k is presented for 3 cycles, done after 25 edges.
    start_sweep();
    chk("t_busy1", int'(busy), 1);
    chk("t_abc1", int'({a, b, c}), 0);
    for (int n = 2; n <= 25; n++) begin
      tick();
      chk($sformatf("t_abc%0d", n), int'({a, b, c}), (n <= 24) ? (n - 1) / 3 : 7);
      if (n == 24) chk("t_done_early", int'(done), 0);
      if (n == 25) chk("t_done_at25", int'(done), 1);
    end
`ifdef E05_CHECKER_MISR_EN
    chk("t_sig_echo", int'(signature), 8'h0F);
`else
    chk("t_sig_echo", int'(signature), 0);
`endif
    check_result("timed_echo", 0, 0, 0, 1, int'(signature));

    // Table of fault models, each launched from DONE.
    for (int i = 0; i < 4; i++) begin
      model(tbl[i].lut, e, fi, fv, p, sig);
      lut = tbl[i].lut;
      start_sweep();
      wait_done(tbl[i].name);
      check_result(tbl[i].name, tbl[i].err, tbl[i].ffi, tbl[i].ffv, tbl[i].pas, sig);
    end

    // Re-start from DONE after a faulty sweep with the good model.
    lut = 32'h6644_2200;
    start_sweep();
    wait_done("pre_restart");
    chk("pre_restart_err", int'(err_count), 4);
    lut = EXP;
    start_sweep();
    chk("restart_done_drop", int'(done), 0);
    chk("restart_err_clr", int'(err_count), 0);
    chk("restart_ffv_clr", int'(first_fail_valid), 0);
    chk("restart_pass_clr", int'(pass), 0);
    wait_done("restart");
    model(EXP, e, fi, fv, p, sig);
    check_result("restart", 0, 0, 0, 1, sig);

    // start while busy is ignored; rst mid-sweep clears everything.
    lut = 32'h6644_2200;
    start_sweep();
    for (int n = 2; n <= 16; n++) begin
      start = (n == 11) ? 1'b1 : 1'b0;
      tick();
      chk($sformatf("mid_abc%0d", n), int'({a, b, c}), (n - 1) / 3);
    end
    start = 1'b0;
    chk("mid_err_before_rst", int'(err_count), 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_abc", int'({a, b, c}), 0);
    chk("mid_rst_err", int'(err_count), 0);
    chk("mid_rst_ffv", int'(first_fail_valid), 0);
    $display("sweep mid_reset busy=%0d done=%0d err=%0d", busy, done, err_count);

    // rst and start together: rst wins.
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    chk("rst_start_busy", int'(busy), 0);
    tick();
    chk("rst_start_busy2", int'(busy), 0);
    chk("rst_start_done", int'(done), 0);

    // Randomized response tables: sparse faults on the good table, or full random.
    for (int r = 0; r < 20; r++) begin
      if (r % 2 == 0) lut = EXP ^ ($urandom & $urandom & $urandom);
      else            lut = $urandom;
      model(lut, e, fi, fv, p, sig);
      start_sweep();
      wait_done($sformatf("rnd%0d", r));
      check_result($sformatf("rnd%0d", r), e, fi, fv, p, sig);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
